lfsr_rng: RTL
=============

# lfsr_rng

Parametrised pseudo-random number source: a configurable-width Fibonacci LFSR plus a range-limited output stage. It replaces the fixed 10-bit generator used for LED/target selection. Out-of-range samples are discarded by rejection sampling rather than folded back, so the distribution has no bias toward low values. Results are delivered through a one-entry valid/ready output register. A runtime seed load, an advance enable, lock-up recovery and a saturating rejection counter are provided for game logic and test.

## Interface
- `WIDTH`, 10: LFSR width in bits; must be at least 3.
- `TAPS`, `10'b10_0100_0000`: feedback mask with `WIDTH` bits. Bit i set means `lfsr[i]` is XORed into the feedback. The default taps bits 9 and 6, giving a maximal-length sequence.
- `SEED`, 1: reset and fallback seed; must be nonzero.
- `MAX_VALUE`, 17: inclusive upper bound of the output.
- `OUT_W`, `$clog2(MAX_VALUE+1)`: derived output width; must be at most `WIDTH`.
- `CNT_W`, 8: width of the rejection counter.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `enable` in 1: when 1, the LFSR advances one step per cycle.
- `seed_load` in 1: loads `seed_value` into the LFSR this cycle.
- `seed_value` in `WIDTH`: seed to load; 0 means use `SEED`.
- `rand_ready` in 1: consumer accepts `rand_value`.
- `rand_valid` out 1: `rand_value` holds an unconsumed sample.
- `rand_value` out `OUT_W`: sample in the range 0..`MAX_VALUE`.
- `reject_count` out `CNT_W`: saturating count of rejected candidates.
- `lockup` out 1: one-cycle pulse when an all-zero LFSR state is detected and repaired.

## Operation
- **Step.** The next LFSR state is `{lfsr[WIDTH-2:0], ^(lfsr & TAPS)}`.
- **Candidate.** The candidate is `lfsr[OUT_W-1:0]` of the current state. It is in range if it is ≤ `MAX_VALUE`.
- **Slot open.** The output slot is open when `!rand_valid || rand_ready`.
- **FSM.** The FSM has two states, EMPTY and FULL, and `rand_valid` = (state == FULL).
- **Priority per cycle:**
  1. **Seed load.** If `seed_load` is 1:
     - `lfsr <= (seed_value == 0) ? SEED : seed_value`.
     - State goes to EMPTY and `rand_valid` is cleared; an unconsumed sample is discarded.
     - `reject_count` is cleared.
     - `enable` is ignored this cycle.
  2. **Lock-up repair.** Else, if `lfsr == 0`: `lfsr <= SEED`, `lockup` pulses, and no capture occurs.
  3. **Normal step.** Else, if `enable` is 1, the LFSR steps. If the slot is open:
     - An in-range candidate is captured into `rand_value` and the state becomes FULL.
     - An out-of-range candidate increments `reject_count`, saturating at all-ones. The state becomes EMPTY if `rand_ready` consumed the held sample, otherwise it stays EMPTY.
  4. **Disabled.** Else (`enable` is 0): the LFSR holds. A `rand_valid && rand_ready` handshake still completes and moves FULL to EMPTY. No capture occurs.
- **Simultaneous consume and capture.** If a consume and an in-range capture happen in the same cycle, the new value replaces the old one and `rand_valid` stays 1. This gives throughput of one sample per cycle when every candidate is in range.
- **Backpressure.** While FULL and `rand_ready` is 0:
  - `rand_value` is held stable.
  - The LFSR keeps stepping when `enable` is 1.
  - Candidates are neither captured nor counted.

## Timing
- **Reset values:** `lfsr` = `SEED`, state EMPTY, `rand_valid` 0, `rand_value` 0, `reject_count` 0, `lockup` 0.
- **Latency.** Capture latency is one edge: a candidate present before an edge appears on `rand_value` after that edge.
- **After a seed load,** the first candidate (the seed itself) is evaluated on the next edge.
- **Registered outputs.** All outputs are registered; there is no combinational path from inputs to outputs.
- **Reset mid-operation.** Asserting `rst_n` low at any time forces the reset values immediately, because the reset is asynchronous.

## Structure
- **Package `rng_pkg`:**
  - State enum `rng_state_t` with values EMPTY and FULL.
  - Constant `RNG_TAPS_10 = 10'b10_0100_0000`.
- **Sub-module `lfsr_core`:**
  - Parameters: `WIDTH`, `TAPS`, `SEED`.
  - Ports: `clk`, `rst_n`, `step`, `load`, `load_value`, `state`, `zero`.
  - Contains the shift register and lock-up detection.
- **Top level** holds the FSM, range check, output register and counter.

## Test plan
- **Reset then free run.** Default parameters, `enable`=1, `rand_ready`=1 after reset. Required: `rand_valid` 1 with values 1, 2, 4, 8, 16, 0, 0, 1 on consecutive edges, and `reject_count` 0.
- **Rejection.** `seed_load`=1 with `seed_value`=31 for one cycle, then `enable`=1 and `rand_ready`=1. Required:
  - Candidates 31, 30, 28, 25, 19 are rejected; `rand_valid` stays 0 for 5 edges.
  - The 6th edge presents 7.
  - `reject_count` reads 5.
- **Backpressure.** Hold `rand_ready`=0 after the first sample (value 1) for 20 cycles. Required: `rand_value` stays 1, `rand_valid` stays 1, and `reject_count` does not change. Then raise `rand_ready` for one cycle: the next capture is a fresh sample.
- **Zero seed and seed flush.** Load with `seed_value`=0 while FULL. Required: `rand_valid` is 0 on the next edge, and the sequence restarts 1, 2, 4.
- **Lock-up.** Use a non-maximal `TAPS` (or force the LFSR to 0). Required: one `lockup` pulse, the LFSR returns to `SEED`, and sampling resumes on the following edge.
- **Async reset.** Assert `rst_n` low mid-stream while FULL and between clock edges. Required: `rand_valid`, `rand_value` and `reject_count` all go to 0 before the next edge.

Source files
------------

// File: rtl/lfsr_rng_pkg.sv
// Shared types and constants for the lfsr_rng random source.
package rng_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } rng_state_t;

    localparam logic [9:0] RNG_TAPS_10 = 10'b10_0100_0000;

endpackage : rng_pkg

// File: rtl/lfsr_rng_if.sv
// Control and valid/ready sample port of lfsr_rng.
interface lfsr_rng_if #(
    parameter int WIDTH = 10,
    parameter int OUT_W = 5,
    parameter int CNT_W = 8
);
    logic             enable;
    logic             seed_load;
    logic [WIDTH-1:0] seed_value;
    logic             rand_ready;
    logic             rand_valid;
    logic [OUT_W-1:0] rand_value;
    logic [CNT_W-1:0] reject_count;
    logic             lockup;

    modport master (
        output enable, seed_load, seed_value, rand_ready,
        input  rand_valid, rand_value, reject_count, lockup
    );

    modport slave (
        input  enable, seed_load, seed_value, rand_ready,
        output rand_valid, rand_value, reject_count, lockup
    );
endinterface : lfsr_rng_if

// File: rtl/lfsr_rng_core.sv
// Fibonacci LFSR with seed load and all-zero lock-up repair.
module lfsr_core
    import rng_pkg::*;
#(
    parameter int               WIDTH = 10,
    parameter logic [WIDTH-1:0] TAPS  = RNG_TAPS_10,
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             step,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] state,
    output logic             zero
);

    logic [WIDTH-1:0] r_lfsr;
    logic             w_feedback;

    assign w_feedback = ^(r_lfsr & TAPS);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr <= SEED;
        end else if (load) begin
            r_lfsr <= load_value;
        end else if (zero) begin
            r_lfsr <= SEED;
        end else if (step) begin
            r_lfsr <= {r_lfsr[WIDTH-2:0], w_feedback};
        end
    end

    assign state = r_lfsr;
    assign zero  = (r_lfsr == '0);

endmodule : lfsr_core

// File: rtl/lfsr_rng.sv
// Range-limited random source: LFSR candidates filtered by rejection sampling into a valid/ready slot.
module lfsr_rng
    import rng_pkg::*;
#(
    parameter int               WIDTH     = 10,
    parameter logic [WIDTH-1:0] TAPS      = RNG_TAPS_10,
    parameter logic [WIDTH-1:0] SEED      = WIDTH'(1),
    parameter int               MAX_VALUE = 17,
    parameter int               OUT_W     = $clog2(MAX_VALUE + 1),
    parameter int               CNT_W     = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    lfsr_rng_if.slave   rng
);

    localparam logic [OUT_W-1:0] MAX_V = OUT_W'(MAX_VALUE);

    rng_state_t       r_state;
    rng_state_t       w_state_nxt;
    logic [OUT_W-1:0] r_value;
    logic [CNT_W-1:0] r_count;
    logic             r_lockup;

    logic [WIDTH-1:0] w_lfsr;
    logic [WIDTH-1:0] w_load_value;
    logic [OUT_W-1:0] w_candidate;
    logic             w_zero;
    logic             w_in_range;
    logic             w_slot_open;
    logic             w_consume;
    logic             w_capture;
    logic             w_reject;

    assign w_load_value = (rng.seed_value == '0) ? SEED : rng.seed_value;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .step       (rng.enable),
        .load       (rng.seed_load),
        .load_value (w_load_value),
        .state      (w_lfsr),
        .zero       (w_zero)
    );

    assign w_candidate = w_lfsr[OUT_W-1:0];
    assign w_in_range  = (w_candidate <= MAX_V);
    assign w_slot_open = (r_state == EMPTY) || rng.rand_ready;
    assign w_consume   = (r_state == FULL) && rng.rand_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // NOTE: defaults first so no path through this block leaves a signal unassigned (no latches).
    always_comb begin
        w_state_nxt = r_state;
        w_capture   = 1'b0;
        w_reject    = 1'b0;
        if (rng.seed_load) begin
            w_state_nxt = EMPTY;
        end else if (w_zero || !rng.enable) begin
            // Repair and idle cycles still let a pending handshake complete.
            if (w_consume) begin
                w_state_nxt = EMPTY;
            end
        end else if (w_slot_open) begin
            if (w_in_range) begin
                w_capture   = 1'b1;
                w_state_nxt = FULL;
            end else begin
                w_reject    = 1'b1;
                w_state_nxt = EMPTY;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_value  <= '0;
            r_count  <= '0;
            r_lockup <= 1'b0;
        end else begin
            r_lockup <= !rng.seed_load && w_zero;
            if (w_capture) begin
                r_value <= w_candidate;
            end
            if (rng.seed_load) begin
                r_count <= '0;
            end else if (w_reject && (r_count != '1)) begin
                r_count <= r_count + 1'b1;
            end
        end
    end

    assign rng.rand_valid   = (r_state == FULL);
    assign rng.rand_value   = r_value;
    assign rng.reject_count = r_count;
    assign rng.lockup       = r_lockup;

endmodule : lfsr_rng
